// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles the two buses of the fetch unit: the read port toward
//   instruction_rom and the valid/ready instruction stream toward decode.
//
//   rom_address  fetch -> rom     ROM word address
//   rom_data     rom   -> fetch   instruction word, valid in the same cycle
//   fetch_valid  fetch -> decode  queue head valid
//   fetch_instr  fetch -> decode  queue head instruction
//   fetch_pc     fetch -> decode  byte PC of queue head
//   fetch_ready  decode -> fetch  decode accepts the head this cycle
//
//   master : the fetch unit side
//   slave  : the ROM + decode side (test environment)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [31:0]           rom_data;
  logic                  fetch_valid;
  logic [31:0]           fetch_instr;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  fetch_ready;

  modport master (
    output rom_address,
    input  rom_data,
    output fetch_valid,
    output fetch_instr,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  rom_address,
    output rom_data,
    input  fetch_valid,
    input  fetch_instr,
    input  fetch_pc,
    output fetch_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Read-side master of instruction_rom. Owns the PC, presents the ROM word
//   address, captures the combinational ROM word into a small FIFO and hands
//   the FIFO head to decode over valid/ready. Supports redirect (flush + new
//   PC) and stops fetching at an all-zero word (end-of-trace marker).
//
//   clk             rising-edge clock
//   reset           synchronous, active-high; highest priority
//   fetch_bus       master modport: rom_address/rom_data and the
//                   fetch_valid/fetch_instr/fetch_pc/fetch_ready stream
//   redirect_valid  flush the queue and load redirect_pc
//   redirect_pc     new PC (bits [1:0] forced to zero)
//   halted          zero word seen; no further fetches until redirect/reset
//   occupancy       number of queued entries
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                   PC_WIDTH     = 32,
  parameter int                   ADDR_WIDTH   = 8,
  parameter int                   QUEUE_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = {PC_WIDTH{1'b0}},
  parameter bit                   HALT_ON_ZERO = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_fetch_unit_if.master     fetch_bus,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic                         halted,
  output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    QD_CNT     = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1'b1);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(3'd4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(2'd3));

  // Architectural state
  logic [PC_WIDTH-1:0] pc_r;
  logic [31:0]         instr_q_r [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] pc_q_r    [QUEUE_DEPTH];
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [CNT_W-1:0]    count_r;
  logic                halted_r;

  // Per-cycle decisions
  logic                head_valid_s;
  logic                pop_s;
  logic                room_s;
  logic                fetch_slot_s;
  logic                zero_word_s;
  logic                enq_s;
  logic                halt_set_s;
  logic [CNT_W-1:0]    count_next_s;

  // Handshake and enqueue decisions for the current cycle.
  always_comb begin
    head_valid_s = (count_r != {CNT_W{1'b0}});
    pop_s        = head_valid_s & fetch_bus.fetch_ready;
    // A full queue still accepts a new word when the head leaves this cycle.
    room_s       = (count_r < QD_CNT) | pop_s;
    fetch_slot_s = ~halted_r & ~redirect_valid & room_s;
    zero_word_s  = HALT_ON_ZERO & (fetch_bus.rom_data == 32'h0000_0000);
    // A zero word consumes the fetch slot but is never queued.
    enq_s        = fetch_slot_s & ~zero_word_s;
    halt_set_s   = fetch_slot_s & zero_word_s;
  end

  // Next occupancy from the enqueue/pop pair (redirect handled in the flop).
  always_comb begin
    count_next_s = count_r;
    case ({enq_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // PC, pointers, occupancy and halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      // Flush: any same-cycle pop is discarded along with the rest.
      pc_r     <= redirect_pc & ALIGN_MASK;
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      halted_r <= 1'b0;
    end else begin
      if (enq_s) begin
        pc_r   <= pc_r + PC_STEP;
        tail_r <= tail_r + PTR_ONE;
      end else begin
        pc_r   <= pc_r;
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      count_r  <= count_next_s;
      halted_r <= halted_r | halt_set_s;
    end
  end

  // Queue storage; cleared on reset so an empty queue reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]    <= {PC_WIDTH{1'b0}};
      end
    end else if (enq_s) begin
      instr_q_r[tail_r] <= fetch_bus.rom_data;
      pc_q_r[tail_r]    <= pc_r;
    end else begin
      instr_q_r[tail_r] <= instr_q_r[tail_r];
      pc_q_r[tail_r]    <= pc_q_r[tail_r];
    end
  end

  // Outputs come straight from registers (the head slot is masked when the
  // queue is empty so stale popped entries never show), so fetch_ready has
  // no combinational path to fetch_valid.
  always_comb begin
    fetch_bus.rom_address = pc_r[ADDR_WIDTH+1:2];
    fetch_bus.fetch_valid = head_valid_s;
    if (head_valid_s) begin
      fetch_bus.fetch_instr = instr_q_r[head_r];
      fetch_bus.fetch_pc    = pc_q_r[head_r];
    end else begin
      fetch_bus.fetch_instr = 32'h0000_0000;
      fetch_bus.fetch_pc    = {PC_WIDTH{1'b0}};
    end
    halted    = halted_r;
    occupancy = count_r;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Drives instruction_fetch_unit with directed scenarios followed by random
//   ready/redirect/reset traffic, comparing every cycle against a queue-based
//   reference model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [2:0]  occupancy;

  logic [31:0] rom_mem [256];

  instruction_fetch_unit_if #(.PC_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  instruction_fetch_unit #(
    .PC_WIDTH    (32),
    .ADDR_WIDTH  (8),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000),
    .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_bus     (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .occupancy     (occupancy)
  );

  // Combinational ROM
  assign bus.rom_data = rom_mem[bus.rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halted;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_pc    = 32'h0;
    e_instr = 32'h0;
    if (m_q.size() != 0) begin
      e_pc    = m_q[0].pc;
      e_instr = m_q[0].instr;
    end
    check("fetch_valid", 64'(bus.fetch_valid), 64'(m_q.size() != 0));
    check("fetch_pc",    64'(bus.fetch_pc),    64'(e_pc));
    check("fetch_instr", 64'(bus.fetch_instr), 64'(e_instr));
    check("occupancy",   64'(occupancy),       64'(m_q.size()));
    check("halted",      64'(halted),          64'(m_halted));
    check("rom_address", 64'(bus.rom_address), 64'(m_pc[9:2]));
  endtask

  // Apply one cycle of inputs (called at negedge), advance the model,
  // then sample at the following negedge.
  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] word;
    bit          pop;
    bit          slot;
    reset           = rst;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.fetch_ready = rdy;
    if (rst) begin
      m_q.delete();
      m_pc     = 32'h0;
      m_halted = 1'b0;
    end else if (rv) begin
      m_q.delete();
      m_pc     = {rpc[31:2], 2'b00};
      m_halted = 1'b0;
    end else begin
      word = rom_mem[m_pc[9:2]];
      pop  = (m_q.size() != 0) && rdy;
      slot = !m_halted && ((m_q.size() < 4) || pop);
      if (pop) void'(m_q.pop_front());
      if (slot) begin
        if (word == 32'h0) begin
          m_halted = 1'b1;
        end else begin
          m_q.push_back('{pc: m_pc, instr: word});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    bus.fetch_ready = 1'b0;
    m_pc            = 32'h0;
    m_halted        = 1'b0;

    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom | 32'h1;
    for (int i = 0; i < 6; i++) rom_mem[i] = 32'h11 + 32'(i);
    rom_mem[6] = 32'h0;

    @(negedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);

    // 1: straight-line run to the zero word
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_romaddr", 64'(bus.rom_address), 64'd6);
    check("t1_valid", 64'(bus.fetch_valid), 64'd0);

    // 2: backpressure fills the queue, then drains without gaps
    step(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_occ", 64'(occupancy), 64'd4);
    check("t2_romaddr", 64'(bus.rom_address), 64'd4);
    check("t2_headpc", 64'(bus.fetch_pc), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 3: full queue with a single-cycle pop keeps occupancy and advances pc
    step(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_occ_full", 64'(occupancy), 64'd4);
    check("t3_romaddr_a", 64'(bus.rom_address), 64'h44);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_occ_keep", 64'(occupancy), 64'd4);
    check("t3_romaddr_b", 64'(bus.rom_address), 64'h45);
    check("t3_headpc", 64'(bus.fetch_pc), 64'h104);

    // 4: redirect with queued entries and ready high; redirect clears halt
    step(1'b0, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_occ3", 64'(occupancy), 64'd3);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    check("t4_occ0", 64'(occupancy), 64'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_pc", 64'(bus.fetch_pc), 64'h40);
    check("t4_instr", 64'(bus.fetch_instr), 64'(rom_mem[16]));
    step(1'b0, 1'b1, 32'h1B, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_halt", 64'(halted), 64'd1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    check("t4_unhalt", 64'(halted), 64'd0);

    // 5: ROM address wrap
    step(1'b0, 1'b1, 32'h3F8, 1'b0);
    check("t5_ra254", 64'(bus.rom_address), 64'd254);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_ra255", 64'(bus.rom_address), 64'd255);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_ra0", 64'(bus.rom_address), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 6: reset mid-stream
    step(1'b0, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_occ3", 64'(occupancy), 64'd3);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("t6_occ0", 64'(occupancy), 64'd0);
    check("t6_valid", 64'(bus.fetch_valid), 64'd0);
    check("t6_romaddr", 64'(bus.rom_address), 64'd0);

    // Random traffic with sparse zero words
    for (int i = 0; i < 24; i++) rom_mem[$urandom_range(255, 0)] = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199, 0) == 0),
           ($urandom_range(24, 0) == 0),
           $urandom,
           ($urandom_range(9, 0) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
